// File: rtl/band_demux_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : band_demux_bank                                               |
// | Brief    : N-channel band demultiplexer with a double-buffered bank.     |
// |            Serial band samples fill per-channel working registers; once  |
// |            every channel holds a sample the set is committed atomically  |
// |            to the output bank with a one-cycle frame strobe.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module band_demux_bank #(
  parameter int WIDTH    = 25,
  parameter int CHANNELS = 3,
  parameter int SEL_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      auto_mode,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       load_onehot,
  output logic                      frame_valid,
  output logic [SEL_W-1:0]          ptr,
  output logic                      sel_error
);

  // One extra bit so CHANNELS == 2^SEL_W still fits in the range compare.
  localparam logic [SEL_W:0]   c_num_ch  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(CHANNELS - 1);

  logic [CHANNELS-1:0][WIDTH-1:0] r_work;
  logic [CHANNELS-1:0][WIDTH-1:0] r_bank;
  logic [CHANNELS-1:0]            r_filled;
  logic [SEL_W-1:0]               r_ptr;
  logic [CHANNELS-1:0]            r_load;
  logic                           r_frame;
  logic                           r_sel_err;

  logic [SEL_W-1:0]               w_target;
  logic                           w_in_range;
  logic                           w_accept;
  logic                           w_reject;
  logic [CHANNELS-1:0]            w_target_oh;
  logic [CHANNELS-1:0]            w_next_filled;
  logic                           w_commit;
  logic [CHANNELS-1:0][WIDTH-1:0] w_merged;
  logic [SEL_W-1:0]               w_ptr_next;

  assign w_target      = auto_mode ? r_ptr : in_sel;
  assign w_in_range    = ({1'b0, w_target} < c_num_ch);
  // clear wins over a simultaneous write, including a rejected one.
  assign w_accept      = in_valid & ~clear & w_in_range;
  assign w_reject      = in_valid & ~clear & ~w_in_range;
  assign w_next_filled = r_filled | w_target_oh;
  assign w_commit      = w_accept & (&w_next_filled);
  assign w_ptr_next    = (r_ptr == c_last_ch) ? '0 : r_ptr + 1'b1;

  // Per-channel decode of the target, and the working set with this cycle's
  // sample merged in so a completing write commits on the same edge.
  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      assign w_target_oh[i] = (w_target == SEL_W'(i));
      assign w_merged[i]    = w_target_oh[i] ? in_data : r_work[i];
    end
  endgenerate

  // Working registers, fill mask and committed output bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_work   <= '0;
      r_bank   <= '0;
      r_filled <= '0;
    end else if (clear) begin
      r_filled <= '0;
    end else if (w_accept) begin
      r_work   <= w_merged;
      r_filled <= w_commit ? '0 : w_next_filled;
      if (w_commit) begin
        r_bank <= w_merged;
      end
    end
  end

  // Round-robin pointer and single-cycle status strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr     <= '0;
      r_load    <= '0;
      r_frame   <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_load    <= w_accept ? w_target_oh : '0;
      r_frame   <= w_commit;
      r_sel_err <= w_reject;
      if (clear) begin
        r_ptr <= '0;
      end else if (w_accept && auto_mode) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign out_data    = r_bank;
  assign load_onehot = r_load;
  assign frame_valid = r_frame;
  assign ptr         = r_ptr;
  assign sel_error   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_band_demux_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_band_demux_bank                                            |
// | Brief    : Self-checking bench for band_demux_bank; a 3x25 and a 5x8     |
// |            instance run side by side against a behavioural model.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_band_demux_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        clear0 = 0, in_valid0 = 0, auto0 = 0;
  logic [3:0]  in_sel0 = '0;
  logic [24:0] in_data0 = '0;
  logic [74:0] out_data0;
  logic [2:0]  load0;
  logic        frame0, err0;
  logic [3:0]  ptr0;

  logic        clear1 = 0, in_valid1 = 0, auto1 = 0;
  logic [2:0]  in_sel1 = '0;
  logic [7:0]  in_data1 = '0;
  logic [39:0] out_data1;
  logic [4:0]  load1;
  logic        frame1, err1;
  logic [2:0]  ptr1;

  int n_checks = 0;
  int n_errors = 0;
  int cnt1 = 0;

  // behavioural model state, index 0 = 3-channel, 1 = 5-channel instance
  logic [24:0] m_work [2][16];
  logic [24:0] m_out  [2][16];
  int          m_filled [2];
  int          m_ptr    [2];
  int          m_load   [2];
  bit          m_frame  [2];
  bit          m_err    [2];

  always #5 clk = ~clk;

  band_demux_bank dut0 (
    .clk(clk), .reset(reset), .clear(clear0), .in_valid(in_valid0),
    .in_data(in_data0), .auto_mode(auto0), .in_sel(in_sel0),
    .out_data(out_data0), .load_onehot(load0), .frame_valid(frame0),
    .ptr(ptr0), .sel_error(err0)
  );

  band_demux_bank #(.WIDTH(8), .CHANNELS(5), .SEL_W(3)) dut1 (
    .clk(clk), .reset(reset), .clear(clear1), .in_valid(in_valid1),
    .in_data(in_data1), .auto_mode(auto1), .in_sel(in_sel1),
    .out_data(out_data1), .load_onehot(load1), .frame_valid(frame1),
    .ptr(ptr1), .sel_error(err1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 16; j++) begin
        m_work[k][j] = '0;
        m_out[k][j]  = '0;
      end
      m_filled[k] = 0; m_ptr[k] = 0; m_load[k] = 0;
      m_frame[k] = 0;  m_err[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int nch, input bit v, input bit c,
                            input bit a, input int sel, input logic [24:0] data);
    int tgt;
    if (c) begin
      m_filled[k] = 0; m_ptr[k] = 0; m_load[k] = 0; m_frame[k] = 0; m_err[k] = 0;
    end else if (!v) begin
      m_load[k] = 0; m_frame[k] = 0; m_err[k] = 0;
    end else begin
      tgt = a ? m_ptr[k] : sel;
      m_frame[k] = 0;
      if (tgt >= nch) begin
        m_err[k]  = 1;
        m_load[k] = 0;
      end else begin
        m_err[k] = 0;
        m_work[k][tgt] = data;
        m_load[k] = 1 << tgt;
        m_filled[k] |= (1 << tgt);
        if (a) m_ptr[k] = (m_ptr[k] + 1) % nch;
        if (m_filled[k] == (1 << nch) - 1) begin
          for (int j = 0; j < nch; j++) m_out[k][j] = m_work[k][j];
          m_frame[k]  = 1;
          m_filled[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [74:0] exp0;
    logic [39:0] exp1;
    for (int i = 0; i < 3; i++) exp0[i*25 +: 25] = m_out[0][i];
    for (int i = 0; i < 5; i++) exp1[i*8 +: 8]   = m_out[1][i][7:0];
    chk("out0",   128'(out_data0), 128'(exp0));
    chk("load0",  128'(load0),     128'(m_load[0]));
    chk("frame0", 128'(frame0),    128'(m_frame[0]));
    chk("ptr0",   128'(ptr0),      128'(m_ptr[0]));
    chk("err0",   128'(err0),      128'(m_err[0]));
    chk("out1",   128'(out_data1), 128'(exp1));
    chk("load1",  128'(load1),     128'(m_load[1]));
    chk("frame1", 128'(frame1),    128'(m_frame[1]));
    chk("ptr1",   128'(ptr1),      128'(m_ptr[1]));
    chk("err1",   128'(err1),      128'(m_err[1]));
  endtask

  // one clock: model both instances on the edge, then check
  task automatic cycle();
    @(posedge clk);
    model_step(0, 3, in_valid0, clear0, auto0, int'(in_sel0), in_data0);
    model_step(1, 5, in_valid1, clear1, auto1, int'(in_sel1), {17'b0, in_data1});
    #1 compare_all();
  endtask

  // drive the 3-channel instance; the 5-channel one streams a counter in auto mode
  task automatic drive0(input bit v, input bit c, input bit a, input int sel, input int data);
    in_valid0 = v; clear0 = c; auto0 = a; in_sel0 = 4'(sel); in_data0 = 25'(data);
    in_valid1 = 1; clear1 = 0; auto1 = 1; in_sel1 = '0; in_data1 = 8'(cnt1 + 1);
    cnt1++;
    cycle();
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b0;
    #1 compare_all();
    @(posedge clk);
    #1 compare_all();
    reset = 1'b1;

    // three samples 1,2,3 in auto mode
    for (int i = 1; i <= 3; i++) drive0(1, 0, 1, 0, i);
    // back-to-back frames 10..15
    for (int i = 10; i <= 15; i++) drive0(1, 0, 1, 0, i);
    drive0(0, 0, 1, 0, 0);
    // external select with overwrite
    drive0(1, 0, 0, 1, 'hA);
    drive0(1, 0, 0, 1, 'hB);
    drive0(1, 0, 0, 0, 'hC);
    drive0(1, 0, 0, 2, 'hD);
    // out-of-range select
    drive0(1, 0, 0, 3, 'h55);
    drive0(1, 0, 0, 15, 'h66);
    drive0(0, 0, 0, 0, 0);
    // clear mid-frame, then a fresh frame
    drive0(1, 0, 1, 0, 1);
    drive0(1, 0, 1, 0, 2);
    drive0(1, 1, 1, 0, 3);
    for (int i = 7; i <= 9; i++) drive0(1, 0, 1, 0, i);

    // randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      in_valid0 = ($urandom_range(0, 3) != 0);
      clear0    = ($urandom_range(0, 15) == 0);
      auto0     = ($urandom_range(0, 2) != 0);
      in_sel0   = 4'($urandom_range(0, 15));
      in_data0  = 25'($urandom);
      in_valid1 = ($urandom_range(0, 3) != 0);
      clear1    = ($urandom_range(0, 15) == 0);
      auto1     = ($urandom_range(0, 2) != 0);
      in_sel1   = 3'($urandom_range(0, 7));
      in_data1  = 8'($urandom);
      cycle();
    end

    // asynchronous reset between edges in the middle of a frame
    in_valid0 = 0; clear0 = 0; in_valid1 = 0; clear1 = 0;
    cycle();
    cnt1 = 0;
    drive0(1, 0, 1, 0, 'h21);
    drive0(1, 0, 1, 0, 'h22);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1 compare_all();
    @(posedge clk);
    #1 compare_all();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) drive0(1, 0, 1, 0, 'h40 + i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
